pcie_write_arbiter: RTL and testbench

PCIE_WRITE_ARBITER -- requirements
Module: pcie_write_arbiter

---
 rtl/pcie_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_pcie_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_write_arbiter.sv
// Round-robin arbiter that funnels per-core write requests into per-core ring
// regions of a shared RAM, gated by host-returned credits.
module pcie_write_arbiter #(
    parameter int N_CORES    = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int CORE_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CORES-1:0]           req,
    input  logic [32*N_CORES-1:0]        data,
    output logic [N_CORES-1:0]           ack,
    input  logic                         cred_valid,
    input  logic [CORE_W-1:0]            cred_core,
    input  logic [DEPTH_LOG2:0]          cred_cnt,
    output logic                         ram_we,
    output logic [CORE_W+DEPTH_LOG2-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    output logic                         cred_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic {IDLE, WRITE} state_e;

    state_e                         state_q, state_d;
    logic [CORE_W-1:0]              grant_q, grant_d;
    logic [CORE_W-1:0]              last_q, last_d;
    logic [DEPTH_LOG2-1:0]          wptr_q [N_CORES];
    logic [DEPTH_LOG2-1:0]          wptr_d [N_CORES];
    logic [N_CORES-1:0]             phase_q, phase_d;
    logic [CW-1:0]                  credit_q [N_CORES];
    logic [CW-1:0]                  credit_d [N_CORES];
    logic [N_CORES-1:0]             ack_q, ack_d;
    logic                           ram_we_q, ram_we_d;
    logic [CORE_W+DEPTH_LOG2-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]                    ram_wdata_q, ram_wdata_d;
    logic                           cred_err_q, cred_err_d;

    logic [N_CORES-1:0]             elig;
    logic [N_CORES-1:0]             data_msbs;
    logic                           unused_msbs;
    logic                           found;
    logic [CORE_W-1:0]              pick;
    int unsigned                    idx;
    logic [CW:0]                    sum;

    always_comb begin
        elig      = '0;
        data_msbs = '0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            elig[k]      = req[k] && (credit_q[k] != '0);
            data_msbs[k] = data[32*k+31];
        end
    end

    // Bit 31 of every data word is replaced by the ring phase bit.
    assign unused_msbs = ^data_msbs;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wptr_d      = wptr_q;
        phase_d     = phase_q;
        credit_d    = credit_q;
        cred_err_d  = cred_err_q;
        ack_d       = '0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        found       = 1'b0;
        pick        = '0;
        idx         = 0;
        sum         = '0;

        case (state_q)
            IDLE: begin
                for (int unsigned i = 1; i <= N_CORES; i++) begin
                    idx = (32'(last_q) + i) % 32'(N_CORES);
                    if (!found && elig[idx]) begin
                        found = 1'b1;
                        pick  = CORE_W'(idx);
                    end
                end
                // Outputs for the WRITE cycle are registered at the pick; the
                // pointer and phase cannot change before that cycle.
                if (found) begin
                    state_d     = WRITE;
                    grant_d     = pick;
                    last_d      = pick;
                    ack_d[pick] = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = {pick, wptr_q[pick]};
                    ram_wdata_d = {phase_q[pick], data[32*pick +: 31]};
                end
            end
            WRITE: begin
                state_d         = IDLE;
                wptr_d[grant_q] = wptr_q[grant_q] + 1'b1;
                if (wptr_q[grant_q] == DEPTH_LOG2'(DEPTH - 1))
                    phase_d[grant_q] = ~phase_q[grant_q];
            end
            default: state_d = IDLE;
        endcase

        // Credit return and write decrement on one core merge into one update.
        for (int unsigned k = 0; k < N_CORES; k++) begin
            sum = {1'b0, credit_q[k]};
            if (cred_valid && (cred_core == CORE_W'(k)))
                sum = sum + {1'b0, cred_cnt};
            if ((state_q == WRITE) && (grant_q == CORE_W'(k)))
                sum = sum - 1'b1;
            if (sum > (CW+1)'(DEPTH)) begin
                credit_d[k] = CW'(DEPTH);
                cred_err_d  = 1'b1;
            end else begin
                credit_d[k] = sum[CW-1:0];
            end
        end
        if (cred_valid && (32'(cred_core) >= 32'(N_CORES)))
            cred_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= CORE_W'(N_CORES - 1);
            wptr_q      <= '{default: '0};
            phase_q     <= '1;
            credit_q    <= '{default: CW'(DEPTH)};
            ack_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cred_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wptr_q      <= wptr_d;
            phase_q     <= phase_d;
            credit_q    <= credit_d;
            ack_q       <= ack_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cred_err_q  <= cred_err_d;
        end
    end

    assign ack       = ack_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cred_err  = cred_err_q;

endmodule

// File: tb/tb_pcie_write_arbiter.sv
// Directed bench for pcie_write_arbiter with hand-computed expectations.
module tb_pcie_write_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   ack;
    logic         cred_valid;
    logic [1:0]   cred_core;
    logic [4:0]   cred_cnt;
    logic         ram_we;
    logic [5:0]   ram_addr;
    logic [31:0]  ram_wdata;
    logic         cred_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_write_arbiter #(.N_CORES(4), .DEPTH_LOG2(4), .CORE_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .cred_valid (cred_valid),
        .cred_core  (cred_core),
        .cred_cnt   (cred_cnt),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cred_err   (cred_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req        = '0;
        cred_valid = 1'b0;
        cred_core  = '0;
        cred_cnt   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int seq [5];
        logic [5:0] addrs [5];
        seq   = '{0, 1, 2, 3, 0};
        addrs = '{6'h00, 6'h10, 6'h20, 6'h30, 6'h01};
        data  = '0;

        // Reset values
        do_reset();
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_we", 64'(ram_we), 64'h0);
        check("rst_addr", 64'(ram_addr), 64'h0);
        check("rst_wdata", 64'(ram_wdata), 64'h0);
        check("rst_err", 64'(cred_err), 64'h0);

        // Single request, two-cycle latency
        data[31:0] = 32'hFFFF_1234;
        req = 4'b0001;
        tick();
        check("t1_ack", 64'(ack), 64'h1);
        check("t1_we", 64'(ram_we), 64'h1);
        check("t1_addr", 64'(ram_addr), 64'h0);
        check("t1_wdata", 64'(ram_wdata), 64'hFFFF_1234);
        req = 4'b0000;
        tick();
        check("t1_idle_ack", 64'(ack), 64'h0);
        check("t1_idle_we", 64'(ram_we), 64'h0);
        check("t1_idle_wdata", 64'(ram_wdata), 64'h0);

        // Round robin with all cores requesting
        do_reset();
        data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_ack", 64'(ack), 64'(4'b0001 << seq[i]));
            check("rr_addr", 64'(ram_addr), 64'(addrs[i]));
            if (i == 3) check("rr_wdata3", 64'(ram_wdata), 64'hC444_4444);
            tick();
            check("rr_gap", 64'(ack), 64'h0);
        end

        // Ring wrap on core 2 with credits returned each write
        do_reset();
        data = '0;
        data[95:64] = 32'h8000_00A5;
        req = 4'b0100;
        for (int i = 0; i < 17; i++) begin
            tick();
            check("wrap_ack", 64'(ack), 64'h4);
            check("wrap_addr", 64'(ram_addr), 64'(6'h20 + 6'(i % 16)));
            check("wrap_wdata", 64'(ram_wdata), (i < 16) ? 64'h8000_00A5 : 64'h0000_00A5);
            cred_valid = 1'b1;
            cred_core  = 2'd2;
            cred_cnt   = 5'd1;
            tick();
            cred_valid = 1'b0;
            check("wrap_gap", 64'(ack), 64'h0);
        end
        check("wrap_err", 64'(cred_err), 64'h0);

        // Credit exhaustion on core 1 does not stall core 3
        do_reset();
        data = '0;
        data[63:32]  = 32'h0000_0B01;
        data[127:96] = 32'h0000_0B03;
        req = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("ex_c1_ack", 64'(ack), 64'h2);
            tick();
        end
        req = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("ex_c3_ack", 64'(ack), 64'h8);
            if (j == 2) begin
                cred_valid = 1'b1;
                cred_core  = 2'd1;
                cred_cnt   = 5'd4;
            end
            tick();
            cred_valid = 1'b0;
            check("ex_gap", 64'(ack), 64'h0);
        end
        tick();
        check("ex_resume_ack", 64'(ack), 64'h2);
        check("ex_resume_addr", 64'(ram_addr), 64'h10);
        check("ex_resume_wdata", 64'(ram_wdata), 64'h0000_0B01);

        // Credit overflow saturates and is sticky
        do_reset();
        cred_valid = 1'b1;
        cred_core  = 2'd0;
        cred_cnt   = 5'd1;
        tick();
        cred_valid = 1'b0;
        check("ovf_err", 64'(cred_err), 64'h1);
        req = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("ovf_ack", 64'(ack), 64'h1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_no_17th", 64'(ack), 64'h0);
        end
        check("ovf_err_sticky", 64'(cred_err), 64'h1);
        rst_n = 1'b0;
        req   = '0;
        tick();
        check("ovf_err_clr", 64'(cred_err), 64'h0);
        rst_n = 1'b1;

        // Reset during a write abandons it
        do_reset();
        data = '0;
        data[63:32] = 32'h1234_5678;
        req = 4'b0010;
        tick();
        check("rw_ack", 64'(ack), 64'h2);
        rst_n = 1'b0;
        tick();
        check("rw_abort_ack", 64'(ack), 64'h0);
        check("rw_abort_we", 64'(ram_we), 64'h0);
        rst_n = 1'b1;
        tick();
        check("rw_retry_ack", 64'(ack), 64'h2);
        check("rw_retry_addr", 64'(ram_addr), 64'h10);
        check("rw_retry_wdata", 64'(ram_wdata), 64'h9234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
